systolic_matmul_engine: RTL
===========================

Name: systolic_matmul_engine

Overview:
Parametrised output-stationary ROWS x COLS signed integer systolic matrix-multiply engine, successor to the fixed 3x3 FIFO-fed array. It computes C = A x B over a programmable reduction length K. Internal input skewing and an explicit start/run/flush/done control FSM replace externally sequenced FIFO enables. Valid/ready handshakes connect it to the upstream operand streamer and the downstream result writer.

Parameters:
ROWS, 4, PE rows (>=1); A-operand lanes
COLS, 4, PE columns (>=1); B-operand lanes
DATA_WIDTH, 16, signed operand width
ACC_WIDTH, 40, signed accumulator width (>= 2*DATA_WIDTH)
K_WIDTH, 8, width of k_len

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; begins a job when FSM is IDLE
k_len  in  K_WIDTH  reduction length K, sampled with start; 0 treated as 1
busy  out  1  high in any state except IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts a beat
in_a  in  ROWS*DATA_WIDTH  column k of A; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
in_b  in  COLS*DATA_WIDTH  row k of B; lane j likewise
out_valid  out  1  result matrix valid
out_ready  in  1  downstream accepts result
out_c  out  ROWS*COLS*ACC_WIDTH  C[i][j] at bits [(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH]
overflow  out  1  sticky per job: some accumulation overflowed signed ACC_WIDTH

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low. All state, including mid-job, clears immediately on reset. After reset: FSM=IDLE, busy=0, in_ready=0, out_valid=0, out_c=0, overflow=0, skew registers=0, accumulators=0.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - On start: latch K=max(k_len,1). Clear all accumulators, overflow, skew and PE pass registers. Go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready. Each accepted beat increments the beat counter.
  - No beat accepted in a cycle: a zero bubble is injected, so stalls are exact.
  - When the Kth beat is accepted: in_ready drops the next cycle and the FSM goes to FLUSH.
- Skew:
  - Lane i of A is delayed i cycles; lane j of B is delayed j cycles (shift registers). Zeros shift in when no beat is accepted.
  - A moves right and B moves down through the PEs with one register per hop.
  - Beat k therefore reaches PE(i,j) i+j cycles after acceptance.
- MAC:
  - acc += sign-extended (a*b). Products are 2*DATA_WIDTH wide, extended to ACC_WIDTH.
  - The sum wraps two's-complement.
  - overflow sets if any PE sees same-sign operands giving an opposite-sign sum. It holds until the next start.
- FLUSH:
  - Counts ROWS+COLS-1 cycles with zero injection, then goes to DONE.
  - out_valid rises exactly ROWS+COLS cycles after the edge that accepted the last beat.
- DONE:
  - out_valid=1. out_c is registered from the accumulators and stable while out_valid=1.
  - On out_valid&&out_ready: out_valid clears next cycle and the FSM goes to IDLE.
  - out_c and overflow hold their values until the next start.
- busy=1 in LOAD/FLUSH/DONE.
- in_valid while not in LOAD is ignored (in_ready=0).
- ROWS=1 or COLS=1 must work; the skew on that dimension degenerates to zero delay.

Test Plan:
- 2x2 build, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_valid held high, out_ready=1 -> out_c=[[19,22],[43,50]]; out_valid exactly 4 cycles after the last beat; overflow=0; busy falls after the handshake.
- 4x4 default build, K=4, A=identity, B=rows {1,2,3,4},{-1,-2,-3,-4},{100,0,0,0},{-32768,32767,0,1} -> out_c equals B, with correct sign extension in 40 bits.
- Same job with in_valid deasserted for 3 cycles between beats 1 and 2 -> identical result; out_valid delayed by exactly 3 cycles.
- DATA_WIDTH=16, ACC_WIDTH=32, 1x1, K=3, a=b=-32768 each beat -> acc wraps to 0x40000000*3 mod 2^32 = 0xC0000000; overflow=1. A following job with small values gives overflow=0.
- out_ready held low 10 cycles in DONE -> out_valid and out_c stable; start pulses and in_valid ignored; completes when out_ready=1.
- rstn asserted mid-LOAD after 2 of 4 beats -> all outputs return to reset values immediately; a fresh K=1 job then produces the correct result with no residue.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// Output-stationary ROWS x COLS signed systolic matrix multiplier computing C = A x B
// over a programmable reduction length, with internal operand skew and job control FSM.
module systolic_matmul_engine #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [K_WIDTH-1:0]                k_len,
  output logic                              busy,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]        in_a,
  input  logic [COLS*DATA_WIDTH-1:0]        in_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ROWS*COLS*ACC_WIDTH-1:0]    out_c,
  output logic                              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

  localparam int FLUSH_W = $clog2(ROWS + COLS) + 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ROWS + COLS - 1);

  state_e                         state_q, state_d;
  logic [K_WIDTH-1:0]             k_q, k_d;
  logic [K_WIDTH-1:0]             beat_q, beat_d;
  logic [FLUSH_W-1:0]             flush_q, flush_d;
  logic [ROWS*COLS*ACC_WIDTH-1:0] out_c_q, out_c_d;
  logic                           overflow_q, overflow_d;

  logic clear, accept, last_beat, flush_end;

  logic signed [DATA_WIDTH-1:0]   a_edge [ROWS];
  logic signed [DATA_WIDTH-1:0]   b_edge [COLS];
  logic signed [DATA_WIDTH-1:0]   a_out  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]   b_out  [ROWS][COLS];
  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_w;
  logic [ROWS*COLS-1:0]           ovf_w;

  assign clear     = (state_q == IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_q == k_q - K_WIDTH'(1));
  assign flush_end = (state_q == FLUSH) && (flush_q == FLUSH_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = LOAD;
      LOAD:    if (last_beat) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DONE);
  end

  // The flush counter drains the skew/PE pipeline and then captures the result one edge later.
  always_comb begin
    k_d        = k_q;
    beat_d     = beat_q;
    flush_d    = flush_q;
    out_c_d    = out_c_q;
    overflow_d = overflow_q | (|ovf_w);
    if (clear) begin
      k_d        = (k_len == '0) ? K_WIDTH'(1) : k_len;
      beat_d     = '0;
      overflow_d = 1'b0;
    end
    if (accept) beat_d = beat_q + K_WIDTH'(1);
    if (state_q == FLUSH) flush_d = flush_q + FLUSH_W'(1);
    else                  flush_d = '0;
    if (flush_end) out_c_d = acc_w;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q        <= '0;
      beat_q     <= '0;
      flush_q    <= '0;
      out_c_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      beat_q     <= beat_d;
      flush_q    <= flush_d;
      out_c_q    <= out_c_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_c    = out_c_q;
  assign overflow = overflow_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    logic signed [DATA_WIDTH-1:0] sa_q [i+1];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int d = 0; d <= i; d++) sa_q[d] <= '0;
      end else if (clear) begin
        for (int d = 0; d <= i; d++) sa_q[d] <= '0;
      end else begin
        sa_q[0] <= accept ? in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int d = 1; d <= i; d++) sa_q[d] <= sa_q[d-1];
      end
    end
    assign a_edge[i] = sa_q[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_b
    logic signed [DATA_WIDTH-1:0] sb_q [j+1];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int d = 0; d <= j; d++) sb_q[d] <= '0;
      end else if (clear) begin
        for (int d = 0; d <= j; d++) sb_q[d] <= '0;
      end else begin
        sb_q[0] <= accept ? in_b[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int d = 1; d <= j; d++) sb_q[d] <= sb_q[d-1];
      end
    end
    assign b_edge[j] = sb_q[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe
      logic signed [DATA_WIDTH-1:0]   a_in, b_in, a_q, b_q;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]    prod_ext, sum, acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_pass
        assign a_in = a_out[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_pass
        assign b_in = b_out[i-1][j];
      end

      assign prod     = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(b_in);
      assign prod_ext = ACC_WIDTH'(prod);
      assign sum      = acc_q + prod_ext;

      // Signed overflow: both addends share a sign that the wrapped sum does not.
      assign ovf_w[i*COLS+j] = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                               (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (clear) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= sum;
        end
      end

      assign a_out[i][j] = a_q;
      assign b_out[i][j] = b_q;
      assign acc_w[(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    end
  end

endmodule
